// File: rtl/button_event_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// button_event_arbiter_pkg
//   Shared definitions for the button event arbiter and its consumers:
//   - default channel count and event-id width
//   - event id constants for the ping-pong game buttons
//   - arbiter FSM state encoding
//   - small helper functions (saturating 8-bit increment, integer max)
// Ports: none (package).
// -----------------------------------------------------------------------------
package button_event_arbiter_pkg;

   localparam int DEF_N_BTN = 5;
   localparam int DEF_IDW   = 3;

   // Channel numbers as wired from the debouncers.
   localparam int EVT_P1_UP = 0;
   localparam int EVT_P1_DN = 1;
   localparam int EVT_P2_UP = 2;
   localparam int EVT_P2_DN = 3;
   localparam int EVT_SERVE = 4;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_OFFER = 1'b1
   } arb_state_t;

   // Counter that sticks at 255 instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/button_event_arbiter_if.sv
// -----------------------------------------------------------------------------
// button_event_arbiter_if
//   Valid/ready event stream from the arbiter to the game-control FSM.
//   Signals:
//     evt_valid  arbiter -> consumer   event offered
//     evt_id     arbiter -> consumer   channel number of the offered event
//     evt_ready  consumer -> arbiter   consumer accepts when evt_valid & evt_ready
//   Modports:
//     master  - arbiter side (drives evt_valid/evt_id)
//     slave   - consumer side (drives evt_ready)
// -----------------------------------------------------------------------------
interface button_event_arbiter_if
   import button_event_arbiter_pkg::*;
#(
   parameter int IDW = DEF_IDW
) ();

   logic           evt_valid;
   logic [IDW-1:0] evt_id;
   logic           evt_ready;

   modport master (
      output evt_valid,
      output evt_id,
      input  evt_ready
   );

   modport slave (
      input  evt_valid,
      input  evt_id,
      output evt_ready
   );

endinterface

// File: rtl/button_event_arbiter_btn_repeat_gen.sv
// -----------------------------------------------------------------------------
// btn_repeat_gen
//   Auto-repeat generator for one button channel. While level is high the hold
//   counter advances once per tick_en; after DELAY ticks one rpt_pulse is
//   emitted, then one every PERIOD ticks. Dropping level clears counter and
//   phase immediately. Only compiled when AUTO_REPEAT_EN is defined.
//   Ports:
//     clk        in  system clock
//     rst        in  synchronous reset, active-high
//     tick_en    in  slow one-clk enable strobe
//     level      in  debounced held level of this button
//     rpt_pulse  out one-clk repeat pulse (registered)
// -----------------------------------------------------------------------------
`ifdef AUTO_REPEAT_EN
module btn_repeat_gen
   import button_event_arbiter_pkg::*;
#(
   parameter int DELAY  = 100,
   parameter int PERIOD = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic tick_en,
   input  logic level,
   output logic rpt_pulse
);

   localparam int CW = $clog2(max_int(DELAY, PERIOD) + 1);

   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic          phase_q, phase_d;   // 0: waiting out DELAY, 1: repeating every PERIOD
   logic          rpt_q, rpt_d;

   always_comb begin
      cnt_d   = cnt_q;
      phase_d = phase_q;
      rpt_d   = 1'b0;
      cnt_inc = cnt_q + CW'(1);
      if (!level) begin
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (tick_en) begin
         if (!phase_q && (cnt_inc == CW'(DELAY))) begin
            rpt_d   = 1'b1;
            phase_d = 1'b1;
            cnt_d   = '0;
         end else if (phase_q && (cnt_inc == CW'(PERIOD))) begin
            rpt_d   = 1'b1;
            cnt_d   = '0;
         end else begin
            cnt_d   = cnt_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q   <= '0;
         phase_q <= 1'b0;
         rpt_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
         rpt_q   <= rpt_d;
      end
   end

   assign rpt_pulse = rpt_q;

endmodule
`endif

// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//   Latches one pending event per button channel and serialises them onto a
//   single valid/ready stream with round-robin priority, so simultaneous
//   presses are never silently lost. Presses that arrive while their channel
//   is already pending are counted in drop_cnt (one count per drop-cycle,
//   saturating at 255).
//   Optional feature macro: AUTO_REPEAT_EN -- adds per-channel hold counters
//   (btn_repeat_gen) that inject repeat requests while btn_level is held.
//   Without it btn_level and tick_en are ignored.
//   Ports:
//     clk        in   system clock (100 MHz)
//     rst        in   synchronous reset, active-high
//     tick_en    in   slow one-clk enable strobe (auto-repeat timing)
//     btn_pulse  in   N_BTN one-cycle debounced press pulses
//     btn_level  in   N_BTN debounced held levels (auto-repeat only)
//     evt_if     master modport: evt_valid/evt_id out, evt_ready in
//     pending    out  N_BTN registered pending flags
//     drop_cnt   out  8-bit saturating dropped-press counter
// -----------------------------------------------------------------------------
module button_event_arbiter
   import button_event_arbiter_pkg::*;
#(
   parameter int N_BTN         = DEF_N_BTN,
   parameter int IDW           = DEF_IDW,
   parameter int REPEAT_DELAY  = 100,
   parameter int REPEAT_PERIOD = 25
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick_en,
   input  logic [N_BTN-1:0]       btn_pulse,
   input  logic [N_BTN-1:0]       btn_level,
   button_event_arbiter_if.master evt_if,
   output logic [N_BTN-1:0]       pending,
   output logic [7:0]             drop_cnt
);

   genvar gi;

   arb_state_t     state_q, state_d;
   logic           evt_valid_q, evt_valid_d;
   logic [IDW-1:0] evt_id_q, evt_id_d;
   logic [IDW-1:0] last_grant_q, last_grant_d;
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [7:0]     drop_cnt_q, drop_cnt_d;

   logic [N_BTN-1:0] req;
   logic [N_BTN-1:0] grant_clr;
   logic [N_BTN-1:0] drop_vec;
   logic             hs;

   // First set bit of req scanning last+1, last+2, ... (mod N_BTN).
   function automatic logic [IDW-1:0] rr_pick(input logic [N_BTN-1:0] req_v,
                                               input logic [IDW-1:0]   last);
      logic [IDW-1:0]   pick;
      logic             found;
      logic [N_BTN-1:0] shifted;
      int               idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= N_BTN; k++) begin
         idx     = (int'(last) + k) % N_BTN;
         shifted = req_v >> idx;
         if (!found && shifted[0]) begin
            pick  = IDW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   // ---------------------------------------------------------------- requests
`ifdef AUTO_REPEAT_EN
   logic [N_BTN-1:0] rpt_pulse;

   for (gi = 0; gi < N_BTN; gi++) begin : g_rpt
      btn_repeat_gen #(
         .DELAY  (REPEAT_DELAY),
         .PERIOD (REPEAT_PERIOD)
      ) u_rpt (
         .clk       (clk),
         .rst       (rst),
         .tick_en   (tick_en),
         .level     (btn_level[gi]),
         .rpt_pulse (rpt_pulse[gi])
      );
   end

   assign req = btn_pulse | rpt_pulse;
`else
   assign req = btn_pulse;

   // Repeat inputs and timing parameters have no function in this build.
   logic unused_repeat_inputs;
   assign unused_repeat_inputs = ^{tick_en, btn_level};
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

   // ---------------------------------------------------------- pending flags
   assign hs        = evt_valid_q & evt_if.evt_ready;
   assign grant_clr = hs ? ({{(N_BTN-1){1'b0}}, 1'b1} << evt_id_q) : '0;

   // A request on the channel being handed off this cycle re-arms it rather
   // than counting as a drop.
   for (gi = 0; gi < N_BTN; gi++) begin : g_chan
      assign pending_d[gi] = req[gi] | (pending_q[gi] & ~grant_clr[gi]);
      assign drop_vec[gi]  = req[gi] & pending_q[gi] & ~grant_clr[gi];
   end

   // Several channels dropping in the same cycle count once.
   assign drop_cnt_d = (|drop_vec) ? sat_inc8(drop_cnt_q) : drop_cnt_q;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_d      = state_q;
      evt_valid_d  = evt_valid_q;
      evt_id_d     = evt_id_q;
      last_grant_d = last_grant_q;
      case (state_q)
         ARB_IDLE: begin
            if (|pending_q) begin
               evt_id_d    = rr_pick(pending_q, last_grant_q);
               evt_valid_d = 1'b1;
               state_d     = ARB_OFFER;
            end else begin
               evt_valid_d = 1'b0;
            end
         end
         ARB_OFFER: begin
            if (hs) begin
               evt_valid_d  = 1'b0;
               last_grant_d = evt_id_q;
               state_d      = ARB_IDLE;
            end
         end
         default: begin
            evt_valid_d = 1'b0;
            state_d     = ARB_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ARB_IDLE;
         evt_valid_q  <= 1'b0;
         evt_id_q     <= '0;
         last_grant_q <= IDW'(N_BTN - 1);   // channel 0 wins first
         pending_q    <= '0;
         drop_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         evt_valid_q  <= evt_valid_d;
         evt_id_q     <= evt_id_d;
         last_grant_q <= last_grant_d;
         pending_q    <= pending_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign evt_if.evt_valid = evt_valid_q;
   assign evt_if.evt_id    = evt_id_q;
   assign pending          = pending_q;
   assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_event_arbiter
//   Directed bench for button_event_arbiter. Expected event ids are queued when
//   the presses are driven and popped when the arbiter completes a handshake.
//   Outputs are sampled on the falling clock edge; inputs change there too.
//   The auto-repeat section is selected by AUTO_REPEAT_EN.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;
   import button_event_arbiter_pkg::*;

   localparam int N   = 5;
   localparam int IDW = 3;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         tick_en = 1'b0;
   logic [N-1:0] btn_pulse = '0;
   logic [N-1:0] btn_level = '0;
   logic [N-1:0] pending;
   logic [7:0]   drop_cnt;

   button_event_arbiter_if #(.IDW(IDW)) evt_if ();

   button_event_arbiter #(
      .N_BTN         (N),
      .IDW           (IDW),
      .REPEAT_DELAY  (4),
      .REPEAT_PERIOD (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .tick_en   (tick_en),
      .btn_pulse (btn_pulse),
      .btn_level (btn_level),
      .evt_if    (evt_if),
      .pending   (pending),
      .drop_cnt  (drop_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic reset_dut();
      @(negedge clk);
      rst = 1'b1;
      btn_pulse = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic pulse(input logic [N-1:0] v);
      btn_pulse = v;
      @(negedge clk);
      btn_pulse = '0;
   endtask

   task automatic wait_valid(input string tag);
      int waited = 0;
      while (!evt_if.evt_valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check(tag, evt_if.evt_valid, 1'b1);
   endtask

   // Wait for n handshakes; each one pops and compares the scoreboard.
   task automatic collect(input int n, input string tag);
      for (int e = 0; e < n; e++) begin
         int waited = 0;
         while (!(evt_if.evt_valid && evt_if.evt_ready) && waited < 40) begin
            @(negedge clk);
            waited++;
         end
         check({tag, "_handshake"}, evt_if.evt_valid && evt_if.evt_ready, 1'b1);
         if (evt_if.evt_valid && evt_if.evt_ready) begin
            if (exp_q.size() == 0) begin
               check({tag, "_sb_underflow"}, 32'd1, 32'd0);
            end else begin
               int exp_id = exp_q.pop_front();
               $display("[%0t] %s: event id=%0d accepted (expected %0d)", $time, tag, evt_if.evt_id, exp_id);
               check({tag, "_id"}, 32'(evt_if.evt_id), 32'(exp_id));
            end
         end
         @(negedge clk);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      evt_if.evt_ready = 1'b0;

      // ---- 1: reset held 3 clk with all pulses asserted
      @(negedge clk);
      rst = 1'b1;
      btn_pulse = 5'b11111;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      btn_pulse = '0;
      check("rst_valid",   evt_if.evt_valid, 1'b0);
      check("rst_id",      evt_if.evt_id, 3'd0);
      check("rst_pending", pending, 5'b00000);
      check("rst_drop",    drop_cnt, 8'd0);
      @(negedge clk);
      check("rst_pending_after", pending, 5'b00000);

      // ---- 3: simultaneous presses, round-robin rotation
      evt_if.evt_ready = 1'b1;
      exp_q.push_back(EVT_P1_UP); exp_q.push_back(EVT_P1_DN); exp_q.push_back(EVT_SERVE);
      pulse(5'b10011);
      collect(3, "simul_a");
      exp_q.push_back(EVT_P1_UP); exp_q.push_back(EVT_P1_DN);
      pulse(5'b00011);
      collect(2, "simul_b");
      // last grant is now 1: scan 2,3,4,0
      exp_q.push_back(EVT_P2_UP); exp_q.push_back(EVT_SERVE); exp_q.push_back(EVT_P1_UP);
      pulse(5'b10101);
      collect(3, "rotate");
      repeat (3) @(negedge clk);
      check("idle_after_rotate", evt_if.evt_valid, 1'b0);

      // ---- 2: single press latency
      exp_q.push_back(EVT_P2_UP);
      pulse(5'b00100);
      check("single_pending_t1", pending, 5'b00100);
      check("single_valid_t1",   evt_if.evt_valid, 1'b0);
      @(negedge clk);
      check("single_valid_t2",   evt_if.evt_valid, 1'b1);
      check("single_id_t2",      evt_if.evt_id, 3'd2);
      collect(1, "single");
      check("single_pending_t3", pending, 5'b00000);
      check("single_drop",       drop_cnt, 8'd0);

      // ---- 4: backpressure, drops, saturation
      evt_if.evt_ready = 1'b0;
      exp_q.push_back(EVT_P2_DN);
      pulse(5'b01000);
      wait_valid("bp_valid");
      for (int c = 0; c < 10; c++) begin
         check("bp_valid_stable", evt_if.evt_valid, 1'b1);
         check("bp_id_stable",    evt_if.evt_id, 3'd3);
         if (c == 2) btn_pulse = 5'b01000;
         else if (c == 4) begin
            btn_pulse = 5'b00001;
            exp_q.push_back(EVT_P1_UP);
         end else btn_pulse = '0;
         @(negedge clk);
      end
      btn_pulse = '0;
      check("bp_drop_one",  drop_cnt, 8'd1);
      check("bp_pending",   pending, 5'b01001);
      btn_pulse = 5'b01000;
      repeat (300) @(negedge clk);
      btn_pulse = '0;
      @(negedge clk);
      check("bp_drop_sat",  drop_cnt, 8'd255);
      check("bp_id_still3", evt_if.evt_id, 3'd3);
      evt_if.evt_ready = 1'b1;
      collect(2, "bp_drain");
      @(negedge clk);
      check("bp_drop_hold", drop_cnt, 8'd255);
      check("bp_pending_clear", pending, 5'b00000);

      // ---- reset in the middle of an offer
      evt_if.evt_ready = 1'b0;
      pulse(5'b00100);
      wait_valid("rstoffer_valid");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rstoffer_valid0",   evt_if.evt_valid, 1'b0);
      check("rstoffer_pending0", pending, 5'b00000);
      check("rstoffer_drop0",    drop_cnt, 8'd0);
      evt_if.evt_ready = 1'b1;
      seen = 0;
      repeat (6) begin
         @(negedge clk);
         if (evt_if.evt_valid) seen++;
      end
      check("rstoffer_no_event", seen, 0);

      // ---- 5: press coincident with handshake of the same channel
      evt_if.evt_ready = 1'b0;
      exp_q.push_back(EVT_P1_DN);
      pulse(5'b00010);
      wait_valid("coin_valid");
      evt_if.evt_ready = 1'b1;
      btn_pulse = 5'b00010;
      exp_q.push_back(EVT_P1_DN);
      collect(1, "coin_first");
      btn_pulse = '0;
      check("coin_pending_kept", pending, 5'b00010);
      check("coin_no_drop",      drop_cnt, 8'd0);
      collect(1, "coin_second");
      check("coin_pending_clear", pending, 5'b00000);

      // evt_ready with nothing offered changes nothing
      repeat (3) @(negedge clk);
      check("ready_idle_valid",   evt_if.evt_valid, 1'b0);
      check("ready_idle_pending", pending, 5'b00000);

`ifdef AUTO_REPEAT_EN
      // ---- 6: auto-repeat, delay 4 ticks then every 2 ticks
      reset_dut();
      evt_if.evt_ready = 1'b1;
      btn_level = 5'b00001;
      for (int tk = 1; tk <= 10; tk++) begin
         int cnt = 0;
         int exp_cnt = (tk == 4 || tk == 6 || tk == 8 || tk == 10) ? 1 : 0;
         if (exp_cnt != 0) exp_q.push_back(EVT_P1_UP);
         tick_en = 1'b1;
         @(negedge clk);
         tick_en = 1'b0;
         repeat (5) begin
            if (evt_if.evt_valid && evt_if.evt_ready) begin
               cnt++;
               if (exp_q.size() != 0) begin
                  int exp_id = exp_q.pop_front();
                  $display("[%0t] repeat tick %0d: event id=%0d accepted", $time, tk, evt_if.evt_id);
                  check("rpt_id", 32'(evt_if.evt_id), 32'(exp_id));
               end
            end
            @(negedge clk);
         end
         check($sformatf("rpt_tick%0d_count", tk), cnt, exp_cnt);
      end
      btn_level = '0;
      seen = 0;
      repeat (6) begin
         tick_en = 1'b1;
         @(negedge clk);
         tick_en = 1'b0;
         repeat (4) begin
            if (evt_if.evt_valid) seen++;
            @(negedge clk);
         end
      end
      check("rpt_released_none", seen, 0);
`else
      // Held levels with ticks must not create events in this build.
      reset_dut();
      evt_if.evt_ready = 1'b1;
      btn_level = 5'b11111;
      seen = 0;
      repeat (12) begin
         tick_en = 1'b1;
         @(negedge clk);
         tick_en = 1'b0;
         repeat (3) begin
            if (evt_if.evt_valid) seen++;
            @(negedge clk);
         end
      end
      btn_level = '0;
      check("level_ignored", seen, 0);
      check("level_ignored_pending", pending, 5'b00000);
`endif

      check("scoreboard_empty", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
